dac_writer: RTL and testbench

Parallel 8-bit DAC write controller: the output-side counterpart to the ADC sampling path. Accepts one code per valid/ready handshake and drives a DAC0832-style bus (data, /CS, /WR, /XFER) with programmable setup, strobe, hold and gap widths. Sits beside the ADC controller and LCD driver under the board top level, so that a sampled or computed code can be re-emitted as an analog level.

---
 rtl/dac_pkg.sv | 26 ++
 rtl/dac_writer_cyc_timer.sv | 27 ++
 rtl/dac_writer.sv | 163 ++++++++++++++++
 tb/tb_dac_writer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC0832-style write controller.
// Holds the FSM state encoding, default strobe timings and the dwell-load helper.
// No logic, no latency, no flow control.
package dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_XFER  = 3'd4,
    ST_GAP   = 3'd5
  } dac_state_t;

  localparam int unsigned DEF_SETUP_CYC  = 2;
  localparam int unsigned DEF_WR_CYC     = 4;
  localparam int unsigned DEF_HOLD_CYC   = 2;
  localparam int unsigned DEF_GAP_CYC    = 2;
  localparam int unsigned DEF_DOUBLE_BUF = 1;

  // A dwell of N cycles is counted by loading N-1 and leaving when the counter reads 0.
  function automatic logic [7:0] dwell_load(input int unsigned n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/dac_writer_cyc_timer.sv
// 8-bit loadable down-counter that times each FSM state dwell.
// Load takes effect on the next edge; o_zero reflects the registered count.
// No backpressure; saturates at zero instead of wrapping.
module cyc_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/dac_writer.sv
// Parallel 8-bit DAC write controller: one code per handshake onto a DAC0832-style bus.
// Latency: code on dac_data one cycle after accept; period 1+S+W+H+G (+W with double buffering).
// Backpressure: din_ready is high only in IDLE; valid without ready is ignored.
module dac_writer
  import dac_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned WR_CYC     = DEF_WR_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC    = DEF_GAP_CYC,
  parameter int unsigned DOUBLE_BUF = DEF_DOUBLE_BUF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dac_data,
  output logic       dac_cs_n,
  output logic       dac_wr_n,
  output logic       dac_xfer_n,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] L_SETUP = dwell_load(SETUP_CYC);
  localparam logic [7:0] L_WR    = dwell_load(WR_CYC);
  localparam logic [7:0] L_HOLD  = dwell_load(HOLD_CYC);
  localparam logic [7:0] L_GAP   = dwell_load(GAP_CYC);
  localparam bit         DB      = (DOUBLE_BUF != 0);

  dac_state_t r_state;
  logic [7:0] r_dac_data;
  logic       r_cs_n;
  logic       r_wr_n;
  logic       r_xfer_n;
  logic       r_din_ready;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic       w_zero;
  logic       w_load;
  logic [7:0] w_load_val;

  assign w_accept = (r_state == ST_IDLE) && din_valid && r_din_ready;

  // Reload the dwell timer with the next state's length on every transition.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = 8'd0;
    case (r_state)
      ST_IDLE: begin
        w_load     = w_accept;
        w_load_val = L_SETUP;
      end
      ST_SETUP: begin
        w_load     = w_zero;
        w_load_val = L_WR;
      end
      ST_WRITE: begin
        w_load     = w_zero;
        w_load_val = L_HOLD;
      end
      ST_HOLD: begin
        w_load     = w_zero;
        w_load_val = DB ? L_WR : L_GAP;
      end
      ST_XFER: begin
        w_load     = w_zero;
        w_load_val = L_GAP;
      end
      ST_GAP: begin
        w_load     = w_zero;
        w_load_val = 8'd0;
      end
      default: begin
        w_load     = 1'b1;
        w_load_val = 8'd0;
      end
    endcase
  end

  cyc_timer u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Sequencer: strobes change on the edge that changes state, so every output is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_dac_data  <= 8'h00;
      r_cs_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_xfer_n    <= 1'b1;
      r_din_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_din_ready <= 1'b1;
          if (w_accept) begin
            r_dac_data  <= din;
            r_cs_n      <= 1'b0;
            r_din_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: if (w_zero) begin
          r_wr_n  <= 1'b0;
          r_state <= ST_WRITE;
        end
        ST_WRITE: if (w_zero) begin
          r_wr_n  <= 1'b1;
          r_state <= ST_HOLD;
        end
        ST_HOLD: if (w_zero) begin
          // CS releases as XFER drops so the latch transfer never overlaps a write.
          r_cs_n <= 1'b1;
          if (DB) begin
            r_xfer_n <= 1'b0;
            r_state  <= ST_XFER;
          end else begin
            r_state  <= ST_GAP;
          end
        end
        ST_XFER: if (w_zero) begin
          r_xfer_n <= 1'b1;
          r_state  <= ST_GAP;
        end
        ST_GAP: if (w_zero) begin
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_din_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_cs_n   <= 1'b1;
          r_wr_n   <= 1'b1;
          r_xfer_n <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign din_ready  = r_din_ready;
  assign dac_data   = r_dac_data;
  assign dac_cs_n   = r_cs_n;
  assign dac_wr_n   = r_wr_n;
  assign dac_xfer_n = r_xfer_n;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_dac_writer.sv
// Directed bench for dac_writer: default timing, single-buffer streaming, minimum timing.
// Outputs sampled 1 time unit after the rising edge; strobe overlap watched on falling edges.
// Expected cycle windows are written out by hand from the timing table.
module tb_dac_writer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // u0: defaults, u1: DOUBLE_BUF=0, u2: all dwells 1
  logic [7:0] din0 = 8'h00, din1 = 8'h00, din2 = 8'h00;
  logic       vld0 = 1'b0, vld1 = 1'b0, vld2 = 1'b0;
  logic       rdy0, rdy1, rdy2;
  logic [7:0] dat0, dat1, dat2;
  logic       cs0, cs1, cs2, wr0, wr1, wr2, xf0, xf1, xf2;
  logic       bsy0, bsy1, bsy2, dn0, dn1, dn2;

  dac_writer u0 (
    .clk(clk), .reset(reset), .din(din0), .din_valid(vld0), .din_ready(rdy0),
    .dac_data(dat0), .dac_cs_n(cs0), .dac_wr_n(wr0), .dac_xfer_n(xf0),
    .busy(bsy0), .done(dn0)
  );

  dac_writer #(.DOUBLE_BUF(0)) u1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(vld1), .din_ready(rdy1),
    .dac_data(dat1), .dac_cs_n(cs1), .dac_wr_n(wr1), .dac_xfer_n(xf1),
    .busy(bsy1), .done(dn1)
  );

  dac_writer #(.SETUP_CYC(1), .WR_CYC(1), .HOLD_CYC(1), .GAP_CYC(1), .DOUBLE_BUF(1)) u2 (
    .clk(clk), .reset(reset), .din(din2), .din_valid(vld2), .din_ready(rdy2),
    .dac_data(dat2), .dac_cs_n(cs2), .dac_wr_n(wr2), .dac_xfer_n(xf2),
    .busy(bsy2), .done(dn2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit 1: WR and XFER both low; bit 0: WR low while CS high. Both must stay 0.
  always @(negedge clk) begin
    chk("ovl0", {6'd0, ~wr0 & ~xf0, ~wr0 & cs0}, 8'd0);
    chk("ovl1", {6'd0, ~wr1 & ~xf1, ~wr1 & cs1}, 8'd0);
    chk("ovl2", {6'd0, ~wr2 & ~xf2, ~wr2 & cs2}, 8'd0);
  end

  // Packed control view: {busy, done, cs_n, wr_n, xfer_n, ready}
  function automatic logic [7:0] ctl(input logic b, input logic d, input logic c,
                                     input logic w, input logic x, input logic r);
    return {2'b00, b, d, c, w, x, r};
  endfunction

  logic [7:0] codes1 [3];
  logic [7:0] codes2 [3];

  initial begin
    codes1[0] = 8'h00; codes1[1] = 8'h7F; codes1[2] = 8'hFF;
    codes2[0] = 8'h01; codes2[1] = 8'h80; codes2[2] = 8'hFE;

    // ---- reset state
    tick();
    tick();
    chk("rst_ctl", ctl(bsy0, dn0, cs0, wr0, xf0, rdy0), ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    chk("rst_dat", dat0, 8'h00);
    reset = 1'b1;
    tick();
    chk("rdy_after_rst", {5'd0, rdy0, rdy1, rdy2}, 8'h07);

    // ---- single write 0xA5, default timing, 15-cycle period
    din0 = 8'hA5;
    vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    din0 = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("t1_ctl_c%0d", k), ctl(bsy0, dn0, cs0, wr0, xf0, rdy0),
          ctl(k <= 14, k == 15, !(k <= 8), !(k >= 3 && k <= 6), !(k >= 9 && k <= 12), k >= 15));
      chk($sformatf("t1_dat_c%0d", k), dat0, 8'hA5);
      tick();
    end

    // ---- DOUBLE_BUF=0 streaming, valid held high, 11-cycle period
    din1 = codes1[0];
    vld1 = 1'b1;
    tick();
    din1 = 8'hEE;
    for (int n = 1; n <= 33; n++) begin
      int k;
      int i;
      k = ((n - 1) % 11) + 1;
      i = (n - 1) / 11;
      chk($sformatf("t2_ctl_n%0d", n), ctl(bsy1, dn1, cs1, wr1, xf1, rdy1),
          ctl(k <= 10, k == 11, !(k <= 8), !(k >= 3 && k <= 6), 1'b1, k == 11));
      chk($sformatf("t2_dat_n%0d", n), dat1, codes1[i]);
      if (k == 11) begin
        if (i < 2) din1 = codes1[i + 1];
        else vld1 = 1'b0;
      end
      tick();
    end
    chk("t2_idle_after", {7'd0, bsy1}, 8'd0);

    // ---- backpressure: 0x33 offered during WRITE of 0x11 is ignored
    din0 = 8'h11;
    vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      chk($sformatf("t3_dat_c%0d", k), dat0, 8'h11);
      chk($sformatf("t3_bsy_c%0d", k), {6'd0, bsy0, rdy0}, {6'd0, k <= 14, k >= 15});
      if (k == 4) begin
        din0 = 8'h33;
        vld0 = 1'b1;
      end else begin
        vld0 = 1'b0;
      end
      tick();
    end

    // ---- minimum dwells, valid held high, 6-cycle period
    din2 = codes2[0];
    vld2 = 1'b1;
    tick();
    din2 = 8'h55;
    for (int n = 1; n <= 18; n++) begin
      int k;
      int i;
      k = ((n - 1) % 6) + 1;
      i = (n - 1) / 6;
      chk($sformatf("t5_ctl_n%0d", n), ctl(bsy2, dn2, cs2, wr2, xf2, rdy2),
          ctl(k <= 5, k == 6, !(k <= 3), k != 2, k != 4, k == 6));
      chk($sformatf("t5_dat_n%0d", n), dat2, codes2[i]);
      if (k == 6) begin
        if (i < 2) din2 = codes2[i + 1];
        else vld2 = 1'b0;
      end
      tick();
    end

    // ---- reset asserted in cycle 4 (mid-WRITE) of a 0x5A write
    din0 = 8'h5A;
    vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_wr_low_c4", {7'd0, wr0}, 8'd0);
    reset = 1'b0;
    #1;
    chk("t4_rst_ctl", ctl(bsy0, dn0, cs0, wr0, xf0, rdy0), ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    chk("t4_rst_dat", dat0, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    chk("t4_rdy_after", ctl(bsy0, dn0, cs0, wr0, xf0, rdy0), ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("t4_nodone_c%0d", k), {6'd0, dn0, bsy0}, 8'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
